// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the UART-to-WS2812 receive path.
package ws2812_pkg;

    typedef enum logic [2:0] {
        FR_IDLE    = 3'd0,
        FR_LEN     = 3'd1,
        FR_DATA    = 3'd2,
        FR_COMMIT  = 3'd3,
        FR_DISCARD = 3'd4
    } frame_state_e;

    localparam logic [7:0]  SOF_BYTE       = 8'h01;
    localparam int unsigned TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/rx_timeout.sv
// Inter-byte silence counter; saturates at the limit and flags expiry while there.
module rx_timeout
    import ws2812_pkg::*;
#(
    parameter int unsigned timeout_cycles = TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);

    localparam int unsigned       CW    = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0]     LIMIT = CW'(timeout_cycles);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/frame_recv.sv
// Parses SOF/length/payload frames from the UART byte stream into the pixel
// buffer and hands completed frames to the send sequencer.
module frame_recv
    import ws2812_pkg::*;
#(
    parameter int unsigned addr_size      = 8,
    parameter int unsigned timeout_cycles = TIMEOUT_CYCLES,
    parameter logic [7:0]  sof_byte       = SOF_BYTE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 send_done,
    output logic                 wr_en,
    output logic [addr_size-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic [addr_size-1:0] length,
    output logic                 trigger,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_overrun
);

    frame_state_e         state_q, state_d;
    logic [addr_size-1:0] len_q, len_d;
    logic [addr_size-1:0] cnt_q, cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic [addr_size-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic [addr_size-1:0] length_q, length_d;
    logic                 trigger_q, trigger_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 tmo_clear;
    logic                 tmo_expired;

    // Idle/commit hold the counter at zero so a fresh frame always starts with a full window.
    assign tmo_clear = rx_valid || (state_q == FR_IDLE) || (state_q == FR_COMMIT);

    rx_timeout #(
        .timeout_cycles(timeout_cycles)
    ) u_rx_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmo_clear),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A byte arriving on the same cycle as expiry still counts, so the full window is usable.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        length_d      = length_q;
        trigger_d     = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        case (state_q)
            FR_IDLE: begin
                if (rx_valid && (rx_data == sof_byte)) begin
                    if (send_done) begin
                        state_d = FR_LEN;
                    end else begin
                        state_d       = FR_DISCARD;
                        err_overrun_d = 1'b1;
                    end
                end
            end
            FR_LEN: begin
                if (rx_valid) begin
                    len_d   = addr_size'(rx_data);
                    cnt_d   = '0;
                    state_d = FR_DATA;
                end else if (tmo_expired) begin
                    state_d       = FR_IDLE;
                    err_timeout_d = 1'b1;
                end
            end
            FR_DATA: begin
                if (rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = rx_data;
                    if (cnt_q == len_q) begin
                        state_d = FR_COMMIT;
                    end else begin
                        cnt_d = cnt_q + addr_size'(1);
                    end
                end else if (tmo_expired) begin
                    state_d       = FR_IDLE;
                    err_timeout_d = 1'b1;
                end
            end
            FR_COMMIT: begin
                length_d  = len_q;
                trigger_d = 1'b1;
                state_d   = FR_IDLE;
            end
            FR_DISCARD: begin
                if (!rx_valid && tmo_expired) begin
                    state_d = FR_IDLE;
                end
            end
            default: begin
                state_d = FR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q         <= '0;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            length_q      <= '0;
            trigger_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            length_q      <= length_d;
            trigger_q     <= trigger_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign length      = length_q;
    assign trigger     = trigger_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign busy        = (state_q != FR_IDLE);

endmodule

// File: tb/tb_frame_recv.sv
// Bench for frame_recv: directed scenarios plus randomized frames checked
// against an event-level model of the frame protocol.
module tb_frame_recv;

    localparam int unsigned TO  = 20;
    localparam int unsigned AW  = 8;
    localparam logic [7:0]  SOF = 8'h01;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          send_done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] length;
    logic          trigger;
    logic          busy;
    logic          err_timeout;
    logic          err_overrun;

    frame_recv #(
        .addr_size     (AW),
        .timeout_cycles(TO),
        .sof_byte      (SOF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .send_done  (send_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .length     (length),
        .trigger    (trigger),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed output events, stamped with the edge that produced them.
    logic [15:0] wr_q[$];
    int          wr_cyc_q[$];
    logic [7:0]  trig_len_q[$];
    int          trig_cyc_q[$];
    int          to_cyc_q[$];
    int          ov_cyc_q[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_q.push_back({wr_addr, wr_data});
            wr_cyc_q.push_back(cyc);
        end
        if (trigger === 1'b1) begin
            trig_len_q.push_back(length);
            trig_cyc_q.push_back(cyc);
        end
        if (err_timeout === 1'b1) to_cyc_q.push_back(cyc);
        if (err_overrun === 1'b1) ov_cyc_q.push_back(cyc);
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pay[256];
    int         model_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap, output int e);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        e        = cyc;
        rx_valid = 1'b0;
        tick(gap);
    endtask

    task automatic clear_q();
        wr_q.delete();
        wr_cyc_q.delete();
        trig_len_q.delete();
        trig_cyc_q.delete();
        to_cyc_q.delete();
        ov_cyc_q.delete();
    endtask

    function automatic int pick_gap(input int mode);
        int r;
        if (mode >= 0) return mode;
        r = int'($urandom_range(0, 4));
        return (r == 4) ? int'(TO) : r;
    endfunction

    function automatic logic [7:0] garbage();
        logic [7:0] b;
        b = 8'($urandom);
        return (b == SOF) ? 8'h02 : b;
    endfunction

    // Expected: payload byte i lands at address i, one trigger one edge after the last write.
    task automatic check_frame(input string tag, input int L, input int last_e);
        tick(3);
        chk({tag, " nwr"}, wr_q.size(), L + 1);
        for (int i = 0; i < wr_q.size() && i <= L; i++)
            chk({tag, " wr"}, wr_q[i], {8'(i), pay[i]});
        if (wr_cyc_q.size() > L) chk({tag, " wr_cyc"}, wr_cyc_q[L], last_e);
        chk({tag, " ntrig"}, trig_len_q.size(), 1);
        if (trig_len_q.size() > 0) begin
            chk({tag, " trig_len"}, trig_len_q[0], L);
            chk({tag, " trig_cyc"}, trig_cyc_q[0], last_e + 1);
        end
        model_len = L;
        chk({tag, " length"}, length, model_len);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " nto"}, to_cyc_q.size(), 0);
        chk({tag, " nov"}, ov_cyc_q.size(), 0);
        clear_q();
    endtask

    task automatic run_frame(input string tag, input int L, input int gapmode, input bit rnd_done);
        int e;
        send(SOF, 0, e);
        chk({tag, " busy_sof"}, busy, 1);
        tick(pick_gap(gapmode));
        send(8'(L), pick_gap(gapmode), e);
        for (int i = 0; i <= L; i++) begin
            if (rnd_done) send_done = 1'($urandom);
            send(pay[i], (i == L) ? 0 : pick_gap(gapmode), e);
        end
        send_done = 1'b1;
        check_frame(tag, L, e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " wr_en"}, wr_en, 0);
        chk({tag, " wr_addr"}, wr_addr, 0);
        chk({tag, " wr_data"}, wr_data, 0);
        chk({tag, " length"}, length, 0);
        chk({tag, " trigger"}, trigger, 0);
        chk({tag, " err_to"}, err_timeout, 0);
        chk({tag, " err_ov"}, err_overrun, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    initial begin
        int e, e_sof, L;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        send_done = 1'b1;
        tick(2);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(2);
        clear_q();

        // Three bytes with gaps
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        run_frame("t1", 2, 3, 1'b0);

        // Single-byte frame, back-to-back
        pay[0] = 8'h5A;
        run_frame("t2", 0, 0, 1'b0);

        // Overrun: sequencer busy, whole frame discarded until silence
        send_done = 1'b0;
        send(SOF, 0, e_sof);
        send(8'h01, 0, e);
        send(8'h11, 0, e);
        send(8'h22, 0, e);
        tick(TO);
        chk("ovr busy_hold", busy, 1);
        tick(1);
        chk("ovr busy_idle", busy, 0);
        tick(2);
        chk("ovr nov", ov_cyc_q.size(), 1);
        if (ov_cyc_q.size() > 0) chk("ovr ov_cyc", ov_cyc_q[0], e_sof);
        chk("ovr nwr", wr_q.size(), 0);
        chk("ovr ntrig", trig_len_q.size(), 0);
        chk("ovr nto", to_cyc_q.size(), 0);
        send_done = 1'b1;
        clear_q();

        // Timeout mid-frame: partial writes, pulse, no trigger
        send(SOF, 0, e);
        send(8'h03, 1, e);
        send(8'h01, 2, e);
        send(8'h02, 0, e);
        tick(TO + 4);
        chk("tmo nwr", wr_q.size(), 2);
        if (wr_q.size() >= 2) begin
            chk("tmo wr0", wr_q[0], 16'h0001);
            chk("tmo wr1", wr_q[1], 16'h0102);
        end
        chk("tmo nto", to_cyc_q.size(), 1);
        if (to_cyc_q.size() > 0) chk("tmo to_cyc", to_cyc_q[0], e + TO + 1);
        chk("tmo ntrig", trig_len_q.size(), 0);
        chk("tmo busy", busy, 0);
        chk("tmo length", length, model_len);
        clear_q();
        pay[0] = 8'h33; pay[1] = 8'h44;
        run_frame("tmo_next", 1, 1, 1'b0);

        // Garbage in idle, then a payload byte equal to SOF
        send(8'h7F, 1, e);
        send(8'h00, 1, e);
        pay[0] = 8'h01; pay[1] = 8'hFF;
        run_frame("sofdata", 1, 1, 1'b0);

        // Reset in the middle of a payload
        send(SOF, 0, e);
        send(8'h03, 0, e);
        send(8'h9A, 1, e);
        send(8'hBC, 1, e);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        reset = 1'b0;
        model_len = 0;
        tick(3);
        chk("midrst ntrig", trig_len_q.size(), 0);
        clear_q();
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        run_frame("midrst_next", 3, 0, 1'b0);

        // Randomized frames: random lengths, gaps up to the full window, idle garbage
        for (int f = 0; f < 8; f++) begin
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) send(garbage(), int'($urandom_range(0, 2)), e);
            L = (f == 5) ? 255 : int'($urandom_range(0, 24));
            for (int i = 0; i <= L; i++) pay[i] = 8'($urandom);
            run_frame("rnd", L, (f == 5) ? 0 : -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
